// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage between the program counter and decode. Issues one instruction
// memory read per PC value, holds the returned word until decode accepts it,
// and steers the PC count/load controls. Redirects (branch/jump/trap) flush the
// held instruction and discard any read still in flight. Only one memory
// request is outstanding at a time; there is no prefetch buffer.
//
// Ports:
//   clk             in   clock, all state on rising edge
//   reset           in   asynchronous active-low reset
//   pc              in   current PC from the program counter
//   pc_count        out  advance PC by 4 at next edge (comb)
//   pc_load         out  load PC with pc_value at next edge (comb)
//   pc_value        out  redirect target forwarded to the PC (comb)
//   redirect        in   single-cycle redirect request from execute
//   redirect_target in   new PC, valid while redirect=1
//   mem_read        out  registered read request
//   mem_addr        out  registered read address, stable while mem_read=1
//   mem_ready       in   memory completes the read this cycle
//   mem_rdata       in   read data, valid with mem_ready
//   instr_valid     out  registered; instr/instr_pc valid for decode
//   instr_ready     in   decode accepts instr this cycle
//   instr           out  held instruction word (NOP_INSTR when flushed/reset)
//   instr_pc        out  address instr was fetched from
// -----------------------------------------------------------------------------
module instruction_fetch #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic        pc_count,
   output logic        pc_load,
   output logic [31:0] pc_value,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StHold = 2'd2,
      StDrop = 2'd3
   } state_e;

   state_e      r_state;
   logic        r_mem_read;
   logic [31:0] r_mem_addr;
   logic        r_instr_valid;
   logic [31:0] r_instr;
   logic [31:0] r_instr_pc;
   logic        w_in_req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= StIdle;
         r_mem_read    <= 1'b0;
         r_mem_addr    <= 32'h0;
         r_instr_valid <= 1'b0;
         r_instr       <= NOP_INSTR;
         r_instr_pc    <= 32'h0;
      end else begin
         unique case (r_state)
            StIdle: begin
               // On a redirect the PC only holds the target after this edge,
               // so wait one cycle before issuing the read.
               if (!redirect) begin
                  r_mem_read <= 1'b1;
                  r_mem_addr <= pc;
                  r_state    <= StReq;
               end
            end
            StReq: begin
               if (mem_ready) begin
                  r_mem_read <= 1'b0;
                  if (!redirect) begin
                     r_instr       <= mem_rdata;
                     r_instr_pc    <= r_mem_addr;
                     r_instr_valid <= 1'b1;
                     r_state       <= StHold;
                  end else begin
                     r_state <= StIdle;
                  end
               end else if (redirect) begin
                  // Read still outstanding: keep the request up and drain it.
                  r_state <= StDrop;
               end
            end
            StHold: begin
               if (redirect) begin
                  r_instr_valid <= 1'b0;
                  r_instr       <= NOP_INSTR;
                  r_state       <= StIdle;
               end else if (instr_ready) begin
                  // pc already advanced when this word returned.
                  r_instr_valid <= 1'b0;
                  r_mem_read    <= 1'b1;
                  r_mem_addr    <= pc;
                  r_state       <= StReq;
               end
            end
            StDrop: begin
               // Further redirects here only reload the PC; last one wins.
               if (mem_ready) begin
                  r_mem_read <= 1'b0;
                  r_state    <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign w_in_req = (r_state == StReq);

   // Redirect has priority, so count and load are never both asserted.
   assign pc_count    = w_in_req & mem_ready & ~redirect;
   assign pc_load     = redirect & reset;
   assign pc_value    = redirect_target;

   assign mem_read    = r_mem_read;
   assign mem_addr    = r_mem_addr;
   assign instr_valid = r_instr_valid;
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        pc_count;
   logic        pc_load;
   logic [31:0] pc_value;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;

   logic [31:0] pc_init;
   int          n_checks;
   int          n_fail;

   instruction_fetch #(.NOP_INSTR(NOP)) dut (
      .clk             (clk),
      .reset           (reset),
      .pc              (pc),
      .pc_count        (pc_count),
      .pc_load         (pc_load),
      .pc_value        (pc_value),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .mem_read        (mem_read),
      .mem_addr        (mem_addr),
      .mem_ready       (mem_ready),
      .mem_rdata       (mem_rdata),
      .instr_valid     (instr_valid),
      .instr_ready     (instr_ready),
      .instr           (instr),
      .instr_pc        (instr_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: program counter and a memory that returns addr + 0x100.
   always @(posedge clk or negedge reset) begin
      if (!reset)        pc <= pc_init;
      else if (pc_load)  pc <= pc_value;
      else if (pc_count) pc <= pc + 32'd4;
   end

   assign mem_rdata = mem_addr + 32'h100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      pc_init         = 32'h0;
      reset           = 1'b0;
      redirect        = 1'b1;
      redirect_target = 32'h123;
      mem_ready       = 1'b1;
      instr_ready     = 1'b1;
      #12;
      // Reset state; redirect must not load the PC while in reset.
      check("rst_mem_read", {31'b0, mem_read}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instr, NOP);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_pc_load", {31'b0, pc_load}, 32'd0);
      check("rst_pc_count", {31'b0, pc_count}, 32'd0);
      redirect = 1'b0;
      #1 reset = 1'b1;

      // Streaming with zero-wait memory and always-ready decode.
      for (int k = 0; k < 3; k++) begin
         step();
         check("seq_mem_read", {31'b0, mem_read}, 32'd1);
         check("seq_mem_addr", mem_addr, 32'(4 * k));
         check("seq_pc_count_req", {31'b0, pc_count}, 32'd1);
         check("seq_valid_req", {31'b0, instr_valid}, 32'd0);
         if (k == 2) instr_ready = 1'b0;
         step();
         check("seq_valid", {31'b0, instr_valid}, 32'd1);
         check("seq_instr", instr, 32'h100 + 32'(4 * k));
         check("seq_instr_pc", instr_pc, 32'(4 * k));
         check("seq_pc_count_hold", {31'b0, pc_count}, 32'd0);
      end

      // Backpressure: decode stalls for 5 cycles in HOLD.
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_valid", {31'b0, instr_valid}, 32'd1);
         check("bp_instr", instr, 32'h108);
         check("bp_instr_pc", instr_pc, 32'h8);
         check("bp_mem_read", {31'b0, mem_read}, 32'd0);
         check("bp_pc_count", {31'b0, pc_count}, 32'd0);
      end
      check("bp_pc", pc, 32'hc);

      // Resume with 3 memory wait states.
      instr_ready = 1'b1;
      mem_ready   = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         check("ws_mem_read", {31'b0, mem_read}, 32'd1);
         check("ws_mem_addr", mem_addr, 32'hc);
         check("ws_valid", {31'b0, instr_valid}, 32'd0);
         check("ws_pc_count", {31'b0, pc_count}, 32'd0);
         if (k < 2) step();
      end
      mem_ready = 1'b1;
      #1;
      check("ws_pc_count_ready", {31'b0, pc_count}, 32'd1);
      check("ws_valid_ready", {31'b0, instr_valid}, 32'd0);
      step();
      check("ws_valid_after", {31'b0, instr_valid}, 32'd1);
      check("ws_instr", instr, 32'h10c);
      check("ws_instr_pc", instr_pc, 32'hc);

      // Redirect during REQ with memory still busy -> DROP.
      mem_ready = 1'b0;
      step();
      check("dr_mem_addr", mem_addr, 32'h10);
      redirect        = 1'b1;
      redirect_target = 32'h200;
      #1;
      check("dr_pc_load", {31'b0, pc_load}, 32'd1);
      check("dr_pc_value", pc_value, 32'h200);
      check("dr_pc_count", {31'b0, pc_count}, 32'd0);
      step();
      redirect = 1'b0;
      check("dr_pc", pc, 32'h200);
      for (int k = 0; k < 2; k++) begin
         check("dr_mem_read", {31'b0, mem_read}, 32'd1);
         check("dr_mem_addr_hold", mem_addr, 32'h10);
         check("dr_valid", {31'b0, instr_valid}, 32'd0);
         if (k == 0) step();
      end
      mem_ready = 1'b1;
      #1;
      check("dr_pc_count_drop", {31'b0, pc_count}, 32'd0);
      step();
      check("dr_idle_mem_read", {31'b0, mem_read}, 32'd0);
      check("dr_idle_valid", {31'b0, instr_valid}, 32'd0);
      step();
      check("dr_new_mem_addr", mem_addr, 32'h200);
      check("dr_new_mem_read", {31'b0, mem_read}, 32'd1);
      step();
      check("dr_new_instr", instr, 32'h300);
      check("dr_new_instr_pc", instr_pc, 32'h200);
      check("dr_new_valid", {31'b0, instr_valid}, 32'd1);

      // Redirect in HOLD with a coincident instr_ready.
      redirect        = 1'b1;
      redirect_target = 32'h400;
      #1;
      check("rh_pc_count", {31'b0, pc_count}, 32'd0);
      check("rh_pc_load", {31'b0, pc_load}, 32'd1);
      step();
      redirect = 1'b0;
      check("rh_valid", {31'b0, instr_valid}, 32'd0);
      check("rh_instr_nop", instr, NOP);
      check("rh_mem_read", {31'b0, mem_read}, 32'd0);
      step();
      check("rh_mem_addr", mem_addr, 32'h400);

      // Redirect coinciding with mem_ready in REQ: data dropped.
      redirect        = 1'b1;
      redirect_target = 32'h500;
      #1;
      check("rm_pc_count", {31'b0, pc_count}, 32'd0);
      step();
      redirect = 1'b0;
      check("rm_valid", {31'b0, instr_valid}, 32'd0);
      check("rm_mem_read", {31'b0, mem_read}, 32'd0);
      check("rm_instr", instr, NOP);
      step();
      check("rm_mem_addr", mem_addr, 32'h500);

      // Async reset mid-REQ, no clock edge involved.
      mem_ready = 1'b0;
      pc_init   = 32'h600;
      #2 reset  = 1'b0;
      #1;
      check("ar_mem_read", {31'b0, mem_read}, 32'd0);
      check("ar_valid", {31'b0, instr_valid}, 32'd0);
      check("ar_mem_addr", mem_addr, 32'h0);
      step();
      step();
      mem_ready = 1'b1;
      reset     = 1'b1;
      step();
      check("ar_restart_addr", mem_addr, 32'h600);
      check("ar_restart_read", {31'b0, mem_read}, 32'd1);
      step();
      check("ar_restart_instr", instr, 32'h700);
      check("ar_restart_pc", instr_pc, 32'h600);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
